demux_rx: RTL and testbench



---
 rtl/demux_rx_if.sv | 33 +++
 rtl/demux_rx.sv | 126 ++++++++++++
 tb/tb_demux_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/demux_rx_if.sv
// Byte-stream and lane bundle for the receive-side 1-to-4 demultiplexer.
// The slave side is the demux itself; the master side feeds bytes and observes lanes.
interface demux_rx_if #(
    parameter int BW = 8,
    parameter int CW = 8
);
    logic [BW-1:0] Entrada;
    logic          validEntrada;
    logic [BW-1:0] Salida0;
    logic [BW-1:0] Salida1;
    logic [BW-1:0] Salida2;
    logic [BW-1:0] Salida3;
    logic          validSalida0;
    logic          validSalida1;
    logic          validSalida2;
    logic          validSalida3;
    logic          activo;
    logic [CW-1:0] conteo_tramas;

    modport master (
        output Entrada, validEntrada,
        input  Salida0, Salida1, Salida2, Salida3,
        input  validSalida0, validSalida1, validSalida2, validSalida3,
        input  activo, conteo_tramas
    );

    modport slave (
        input  Entrada, validEntrada,
        output Salida0, Salida1, Salida2, Salida3,
        output validSalida0, validSalida1, validSalida2, validSalida3,
        output activo, conteo_tramas
    );
endinterface

// File: rtl/demux_rx.sv
// Receive-side 1-to-4 TDM byte demultiplexer on clk_4f; frames are committed on slot 3.
// Optional macro DEMUX_RX_HOLD_EN: invalid lanes keep their previous data instead of zero.
module demux_rx #(
    parameter int BW = 8,
    parameter int CW = 8
) (
    input logic        clk_4f,
    input logic        reset,
    demux_rx_if.slave  bus
);

    typedef enum logic {
        ESPERA = 1'b0,
        ACTIVO = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    slot_q, slot_d;
    logic [BW-1:0] stageData_q [3];
    logic [BW-1:0] stageData_d [3];
    logic [2:0]    stageValid_q, stageValid_d;
    logic [BW-1:0] salida_q [4];
    logic [BW-1:0] salida_d [4];
    logic [3:0]    validSalida_q, validSalida_d;
    logic [CW-1:0] conteo_q, conteo_d;

    logic [BW-1:0] frameData [4];
    logic [3:0]    frameValid;
    logic          commit;

    // Slot 3 bypasses staging: the live input completes the frame on the commit cycle.
    always_comb begin
        frameData[0] = stageData_q[0];
        frameData[1] = stageData_q[1];
        frameData[2] = stageData_q[2];
        frameData[3] = bus.Entrada;
        frameValid   = {bus.validEntrada, stageValid_q};
        commit       = (slot_q == 2'd3);
    end

    always_comb begin
        slot_d       = slot_q + 2'd1;
        stageData_d  = stageData_q;
        stageValid_d = stageValid_q;
        case (slot_q)
            2'd0: begin
                stageData_d[0]  = bus.Entrada;
                stageValid_d[0] = bus.validEntrada;
            end
            2'd1: begin
                stageData_d[1]  = bus.Entrada;
                stageValid_d[1] = bus.validEntrada;
            end
            2'd2: begin
                stageData_d[2]  = bus.Entrada;
                stageValid_d[2] = bus.validEntrada;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        salida_d      = salida_q;
        validSalida_d = validSalida_q;
        conteo_d      = conteo_q;
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                validSalida_d[i] = frameValid[i];
                if (frameValid[i]) begin
                    salida_d[i] = frameData[i];
                end else begin
`ifdef DEMUX_RX_HOLD_EN
                    salida_d[i] = salida_q[i];
`else
                    salida_d[i] = '0;
`endif
                end
            end
            if (|frameValid) begin
                conteo_d = conteo_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERA:  if (bus.validEntrada) state_d = ACTIVO;
            ACTIVO:  state_d = ACTIVO;
            default: state_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q       <= ESPERA;
            slot_q        <= 2'd0;
            stageValid_q  <= '0;
            validSalida_q <= '0;
            conteo_q      <= '0;
            for (int i = 0; i < 3; i++) stageData_q[i] <= '0;
            for (int i = 0; i < 4; i++) salida_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            stageValid_q  <= stageValid_d;
            validSalida_q <= validSalida_d;
            conteo_q      <= conteo_d;
            for (int i = 0; i < 3; i++) stageData_q[i] <= stageData_d[i];
            for (int i = 0; i < 4; i++) salida_q[i] <= salida_d[i];
        end
    end

    assign bus.Salida0       = salida_q[0];
    assign bus.Salida1       = salida_q[1];
    assign bus.Salida2       = salida_q[2];
    assign bus.Salida3       = salida_q[3];
    assign bus.validSalida0  = validSalida_q[0];
    assign bus.validSalida1  = validSalida_q[1];
    assign bus.validSalida2  = validSalida_q[2];
    assign bus.validSalida3  = validSalida_q[3];
    assign bus.activo        = (state_q == ACTIVO);
    assign bus.conteo_tramas = conteo_q;

endmodule

// File: tb/tb_demux_rx.sv
// Self-checking bench for demux_rx: queue-based frame model, directed literals, random streams.
module tb_demux_rx;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    demux_rx_if #(.BW(8), .CW(8)) bus ();

    demux_rx #(.BW(8), .CW(8)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
    } slot_t;

    slot_t      inQ[$];
    logic [7:0] expSal [4];
    logic [3:0] expVal;
    logic [7:0] expCnt;
    logic       expAct;
    bit         checkEn = 1'b0;
    int         vecCount = 0;
    int         missCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bytes since reset are gathered in fours; every complete quadruple is one frame.
    always @(posedge clk_4f) begin
        if (reset) begin
            inQ.delete();
            for (int i = 0; i < 4; i++) expSal[i] = 8'h00;
            expVal = 4'h0;
            expCnt = 8'h00;
            expAct = 1'b0;
        end else begin
            expAct = expAct | bus.validEntrada;
            inQ.push_back('{d: bus.Entrada, v: bus.validEntrada});
            if (inQ.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    slot_t s;
                    s = inQ.pop_front();
                    expVal[i] = s.v;
`ifdef DEMUX_RX_HOLD_EN
                    if (s.v) expSal[i] = s.d;
`else
                    expSal[i] = s.v ? s.d : 8'h00;
`endif
                end
                if (expVal != 4'h0) expCnt = expCnt + 8'd1;
            end
        end
    end

    always @(negedge clk_4f) begin
        if (checkEn) begin
            checkOutput("Salida0", 32'(bus.Salida0), 32'(expSal[0]));
            checkOutput("Salida1", 32'(bus.Salida1), 32'(expSal[1]));
            checkOutput("Salida2", 32'(bus.Salida2), 32'(expSal[2]));
            checkOutput("Salida3", 32'(bus.Salida3), 32'(expSal[3]));
            checkOutput("validSalida", 32'({bus.validSalida3, bus.validSalida2,
                                            bus.validSalida1, bus.validSalida0}), 32'(expVal));
            checkOutput("activo", 32'(bus.activo), 32'(expAct));
            checkOutput("conteo_tramas", 32'(bus.conteo_tramas), 32'(expCnt));
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic r);
        bus.Entrada      = d;
        bus.validEntrada = v;
        reset            = r;
        @(posedge clk_4f);
        #2;
    endtask

    task automatic applyFrame(input logic [31:0] bytes, input logic [3:0] valids);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] b;
            b = bytes >> (8 * (3 - i));
            applyStimulus(b[7:0], valids[3 - i], 1'b0);
        end
    endtask

    initial begin
        bus.Entrada      = 8'h00;
        bus.validEntrada = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkEn = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b1);

        // Bytes listed slot 0 first; valid bits written slot0..slot3 left to right.
        applyFrame(32'hFFEEDDCC, 4'b1111);
        checkOutput("lit_s0_FF", 32'(bus.Salida0), 32'hFF);
        checkOutput("lit_s1_EE", 32'(bus.Salida1), 32'hEE);
        checkOutput("lit_s2_DD", 32'(bus.Salida2), 32'hDD);
        checkOutput("lit_s3_CC", 32'(bus.Salida3), 32'hCC);
        checkOutput("lit_valid_1111", 32'({bus.validSalida3, bus.validSalida2,
                                           bus.validSalida1, bus.validSalida0}), 32'hF);
        checkOutput("lit_cnt_1", 32'(bus.conteo_tramas), 32'd1);
        checkOutput("lit_act_1", 32'(bus.activo), 32'd1);

        applyStimulus(8'h10, 1'b1, 1'b0);
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h12, 1'b1, 1'b0);
        checkOutput("lit_hold_s0", 32'(bus.Salida0), 32'hFF);
        checkOutput("lit_hold_s3", 32'(bus.Salida3), 32'hCC);
        applyStimulus(8'h13, 1'b1, 1'b0);
        checkOutput("lit_frameB_s1", 32'(bus.Salida1), 32'h11);

        applyFrame(32'hAA55BBCC, 4'b1011);
        checkOutput("lit_v1_low", 32'(bus.validSalida1), 32'd0);
        checkOutput("lit_v0_high", 32'(bus.validSalida0), 32'd1);
`ifdef DEMUX_RX_HOLD_EN
        checkOutput("lit_s1_held", 32'(bus.Salida1), 32'h11);
`else
        checkOutput("lit_s1_zero", 32'(bus.Salida1), 32'h00);
`endif
        checkOutput("lit_s0_AA", 32'(bus.Salida0), 32'hAA);
        checkOutput("lit_cnt_3", 32'(bus.conteo_tramas), 32'd3);

        applyFrame(32'h01020304, 4'b0000);
        checkOutput("lit_invalid_cnt", 32'(bus.conteo_tramas), 32'd3);

        applyStimulus(8'h00, 1'b0, 1'b1);
        applyFrame(32'h99887766, 4'b0000);
        checkOutput("lit_act_stays_0", 32'(bus.activo), 32'd0);
        checkOutput("lit_cnt_0", 32'(bus.conteo_tramas), 32'd0);

        applyStimulus(8'h31, 1'b1, 1'b0);
        applyStimulus(8'h32, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b1, 1'b1);
        checkOutput("lit_rst_s0", 32'(bus.Salida0), 32'h00);
        checkOutput("lit_rst_act", 32'(bus.activo), 32'd0);
        checkOutput("lit_rst_cnt", 32'(bus.conteo_tramas), 32'd0);
        applyFrame(32'h5A5B5C5D, 4'b1111);
        checkOutput("lit_post_rst_s0", 32'(bus.Salida0), 32'h5A);
        checkOutput("lit_post_rst_cnt", 32'(bus.conteo_tramas), 32'd1);

        applyStimulus(8'h00, 1'b0, 1'b1);
        for (int f = 1; f <= 256; f++) begin
            applyFrame({8'(f), 24'h0}, 4'b1000);
            if (f == 255) checkOutput("lit_cnt_255", 32'(bus.conteo_tramas), 32'd255);
        end
        checkOutput("lit_cnt_wrap", 32'(bus.conteo_tramas), 32'd0);

        // Random traffic with occasional resets at arbitrary slot positions.
        for (int c = 0; c < 4000; c++) begin
            applyStimulus(8'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 399) == 0));
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
